// File: rtl/jt51_decim.sv
// Stereo decimator: averages 2^LOG2D strobed stereo samples through one shared adder.
// Optional `JT51_DECIM_ROUND_EN adds half an LSB before the output shift (round half toward +inf).
module jt51_decim #(
   parameter int LOG2D = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sample_in,
   input  logic signed [15:0] left_in,
   input  logic signed [15:0] right_in,
   output logic signed [15:0] out_l,
   output logic signed [15:0] out_r,
   output logic               sample_out,
   output logic               overrun
);

   // state  | meaning
   // IDLE   | waiting for an input strobe
   // ADD_L  | shared adder accumulates held left sample
   // ADD_R  | shared adder accumulates held right sample, window check
   // DUMP   | publish averages, pulse sample_out, clear window

   localparam int AW    = 16 + LOG2D;
   localparam int CW    = (LOG2D > 0) ? LOG2D : 1;
   localparam int DECIM = 1 << LOG2D;
`ifdef JT51_DECIM_ROUND_EN
   localparam int RND   = (LOG2D > 0) ? (1 << (LOG2D - 1)) : 0;
`else
   localparam int RND   = 0;
`endif
   localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADD_L,
      ST_ADD_R,
      ST_DUMP
   } state_t;

   state_t              state, state_nx;
   logic signed [15:0]  hold_l, hold_r;
   logic signed [AW-1:0] acc_l, acc_r;
   logic signed [AW-1:0] add_a, add_b, add_y;
   logic [CW-1:0]       cnt;
   logic                last;

   assign last = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (sample_in) state_nx = ST_ADD_L;
         ST_ADD_L: state_nx = ST_ADD_R;
         ST_ADD_R: state_nx = last ? ST_DUMP : ST_IDLE;
         ST_DUMP:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // One adder serves both channels; the operand mux follows the FSM phase.
   always_comb begin
      add_a = (state == ST_ADD_L) ? acc_l : acc_r;
      add_b = AW'((state == ST_ADD_L) ? hold_l : hold_r);
      add_y = add_a + add_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_l     <= '0;
         hold_r     <= '0;
         acc_l      <= '0;
         acc_r      <= '0;
         cnt        <= '0;
         out_l      <= '0;
         out_r      <= '0;
         sample_out <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         sample_out <= 1'b0;
         if (sample_in && state != ST_IDLE) overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (sample_in) begin
                  hold_l <= left_in;
                  hold_r <= right_in;
               end
            end
            ST_ADD_L: acc_l <= add_y;
            ST_ADD_R: begin
               acc_r <= add_y;
               if (!last) cnt <= cnt + 1'b1;
            end
            ST_DUMP: begin
               out_l      <= 16'((acc_l + AW'(RND)) >>> LOG2D);
               out_r      <= 16'((acc_r + AW'(RND)) >>> LOG2D);
               sample_out <= 1'b1;
               acc_l      <= '0;
               acc_r      <= '0;
               cnt        <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
